// File: rtl/ifetch_unit.sv
// Purpose : instruction-fetch stage; owns the PC, fetches over im_req/im_ack and holds the word for the controller.
// Latency : ack in the first request cycle -> instr_valid the next cycle; PCWr -> new im_req the next cycle.
// Backpres: im_req/im_addr held until im_ack; executing instruction held until PCWr; misaligned target halts until reset.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   im_req/im_addr           fetch request and address (= pc) toward instruction memory
//   im_ack/im_rdata          memory acknowledge, data valid in the ack cycle
//   PCWr/NPCOp/Zero/rs_data  controller retire strobe, next-PC select, BEQ result, JR target
//   instr/Op/Funct           current instruction and decode fields, zero while instr_valid=0
//   pc/pc_plus4              current instruction address and its JAL link value
//   instr_valid              instruction register holds a fetched word
//   misalign_err             sticky flag: a retired instruction produced a non-word-aligned next PC
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [31:0]       im_rdata,
    input  logic              PCWr,
    input  logic [1:0]        NPCOp,
    input  logic              Zero,
    input  logic [31:0]       rs_data,
    output logic [31:0]       instr,
    output logic [5:0]        Op,
    output logic [5:0]        Funct,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BEQ = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              misalign_q;

    logic              ld_instr;
    logic              ld_pc;
    logic              set_err;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] br_off;

    // ------------------------------------------------------------------
    // Next-PC selection, always from the registered instruction word.
    // ------------------------------------------------------------------
    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (NPCOp)
            NPC_SEQ: npc = pc_plus4;
            NPC_BEQ: npc = Zero ? (pc_plus4 + br_off) : pc_plus4;
            NPC_J:   npc = {pc_plus4[ADDR_W-1:ADDR_W-4], instr_q[25:0], 2'b00};
            default: npc = rs_data;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        im_req      = 1'b0;
        instr_valid = 1'b0;
        ld_instr    = 1'b0;
        ld_pc       = 1'b0;
        set_err     = 1'b0;
        case (state_q)
            S_FETCH: begin
                // The reset state is S_FETCH, so the request is qualified
                // with rst to drop it the moment reset is asserted.
                im_req = rst;
                if (im_ack) begin
                    ld_instr = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (PCWr) begin
                    if (npc[1:0] == 2'b00) begin
                        ld_pc   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        set_err = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            if (ld_pc) begin
                pc_q <= npc;
            end
            if (ld_instr) begin
                instr_q <= im_rdata;
            end
            if (set_err) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Gated to zero when not valid so the controller decodes SLL $0 (NOP).
    assign instr        = instr_valid ? instr_q : 32'd0;
    assign Op           = instr[31:26];
    assign Funct        = instr[5:0];
    assign pc           = pc_q;
    assign im_addr      = pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Purpose : self-checking bench for ifetch_unit (default and wrap-around reset PC instances).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpres: memory model acks after a programmable number of request cycles.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        PCWr;
    logic [1:0]  NPCOp;
    logic        Zero;
    logic [31:0] rs_data;
    logic [31:0] instr;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign_err;

    logic        im_req2;
    logic [31:0] im_addr2;
    logic        im_ack2;
    logic [31:0] im_rdata2;
    logic        PCWr2;
    logic [1:0]  NPCOp2;
    logic [31:0] instr2;
    logic [5:0]  Op2;
    logic [5:0]  Funct2;
    logic [31:0] pc2;
    logic [31:0] pc_plus4_2;
    logic        instr_valid2;
    logic        misalign_err2;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_addr_q[$];

    ifetch_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .im_req       (im_req),
        .im_addr      (im_addr),
        .im_ack       (im_ack),
        .im_rdata     (im_rdata),
        .PCWr         (PCWr),
        .NPCOp        (NPCOp),
        .Zero         (Zero),
        .rs_data      (rs_data),
        .instr        (instr),
        .Op           (Op),
        .Funct        (Funct),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .misalign_err (misalign_err)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .im_req       (im_req2),
        .im_addr      (im_addr2),
        .im_ack       (im_ack2),
        .im_rdata     (im_rdata2),
        .PCWr         (PCWr2),
        .NPCOp        (NPCOp2),
        .Zero         (1'b0),
        .rs_data      (32'd0),
        .instr        (instr2),
        .Op           (Op2),
        .Funct        (Funct2),
        .pc           (pc2),
        .pc_plus4     (pc_plus4_2),
        .instr_valid  (instr_valid2),
        .misalign_err (misalign_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: wait for a request, compare its address with the
    // scoreboard, hold off wait_cyc cycles, then ack with rdata.
    task automatic fetch(input logic [31:0] rdata, input int wait_cyc, input bit pcwr_noise);
        logic [31:0] exp;
        int          n;
        n = 0;
        while (!im_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, im_req}, 32'd1);
        if (exp_addr_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            exp = 32'hXXXX_XXXX;
        end else begin
            exp = exp_addr_q.pop_front();
        end
        check("im_addr", im_addr, exp);
        for (int i = 0; i < wait_cyc; i++) begin
            // PCWr with a misaligned JR target must be ignored while fetching.
            PCWr    = pcwr_noise;
            NPCOp   = 2'b11;
            rs_data = 32'h0000_3002;
            @(negedge clk);
            check("req_hold", {31'd0, im_req}, 32'd1);
            check("addr_hold", im_addr, exp);
            check("valid_low", {31'd0, instr_valid}, 32'd0);
        end
        PCWr     = 1'b0;
        im_ack   = 1'b1;
        im_rdata = rdata;
        @(negedge clk);
        im_ack   = 1'b0;
        im_rdata = $urandom;
        check("instr_valid", {31'd0, instr_valid}, 32'd1);
        check("req_drop", {31'd0, im_req}, 32'd0);
        check("instr", instr, rdata);
        check("Op", {26'd0, Op}, {26'd0, rdata[31:26]});
        check("Funct", {26'd0, Funct}, {26'd0, rdata[5:0]});
        check("pc", pc, exp);
        check("pc_plus4", pc_plus4, exp + 32'd4);
    endtask

    task automatic retire(input logic [1:0] op, input bit z, input logic [31:0] rs);
        PCWr    = 1'b1;
        NPCOp   = op;
        Zero    = z;
        rs_data = rs;
        @(negedge clk);
        PCWr    = 1'b0;
        NPCOp   = 2'b00;
        Zero    = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        rst       = 1'b0;
        im_ack    = 1'b0;
        im_rdata  = 32'd0;
        PCWr      = 1'b0;
        NPCOp     = 2'b00;
        Zero      = 1'b0;
        rs_data   = 32'd0;
        im_ack2   = 1'b0;
        im_rdata2 = 32'd0;
        PCWr2     = 1'b0;
        NPCOp2    = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, im_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_err", {31'd0, misalign_err}, 32'd0);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_instr", instr, 32'd0);
        rst = 1'b1;
        #1;
        check("req_after_rst", {31'd0, im_req}, 32'd1);

        // LUI with a two-cycle memory latency, then sequential advance
        exp_addr_q.push_back(32'h0000_3000);
        fetch(32'h3C01_1234, 2, 1'b0);
        check("lui_Op", {26'd0, Op}, 32'h0000_000F);
        exp_addr_q.push_back(32'h0000_3004);
        retire(2'b00, 1'b0, 32'd0);
        fetch(32'h0000_0000, 0, 1'b0);
        exp_addr_q.push_back(32'h0000_3008);
        retire(2'b00, 1'b0, 32'd0);

        // BEQ taken: 0x300C - 8
        fetch(32'h1000_FFFE, 1, 1'b1);
        exp_addr_q.push_back(32'h0000_3004);
        retire(2'b01, 1'b1, 32'd0);
        fetch(32'h0000_0000, 0, 1'b0);
        exp_addr_q.push_back(32'h0000_3008);
        retire(2'b00, 1'b0, 32'd0);

        // BEQ not taken
        fetch(32'h1000_FFFE, 0, 1'b0);
        exp_addr_q.push_back(32'h0000_300C);
        retire(2'b01, 1'b0, 32'd0);
        fetch(32'h0000_0000, 3, 1'b1);
        exp_addr_q.push_back(32'h0000_3010);
        retire(2'b00, 1'b0, 32'd0);

        // J
        fetch(32'h0800_0C10, 1, 1'b0);
        check("j_pc_plus4", pc_plus4, 32'h0000_3014);
        exp_addr_q.push_back(32'h0000_3040);
        retire(2'b10, 1'b0, 32'd0);
        fetch(32'h0000_0020, 0, 1'b0);

        // Ack while executing is ignored
        im_ack   = 1'b1;
        im_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        im_ack   = 1'b0;
        check("exec_ack_instr", instr, 32'h0000_0020);
        check("exec_ack_req", {31'd0, im_req}, 32'd0);
        check("exec_hold_valid", {31'd0, instr_valid}, 32'd1);

        // JR to a misaligned target halts
        retire(2'b11, 1'b0, 32'h0000_3002);
        check("jr_err", {31'd0, misalign_err}, 32'd1);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_instr", instr, 32'd0);
        for (int i = 0; i < 10; i++) begin
            PCWr = 1'b1;
            im_ack = 1'b0;
            @(negedge clk);
            check("halt_req", {31'd0, im_req}, 32'd0);
        end
        PCWr = 1'b0;
        check("halt_pc", pc, 32'h0000_3040);
        check("halt_err_sticky", {31'd0, misalign_err}, 32'd1);

        // Reset pulse clears the error and refetches RESET_PC
        rst = 1'b0;
        #1;
        check("clr_err", {31'd0, misalign_err}, 32'd0);
        check("clr_pc", pc, 32'h0000_3000);
        @(negedge clk);
        rst = 1'b1;
        exp_addr_q.push_back(32'h0000_3000);
        fetch(32'h8C22_0004, 0, 1'b0);

        // Reset while a request is pending; ack during reset is ignored
        retire(2'b00, 1'b0, 32'd0);
        check("pend_req", {31'd0, im_req}, 32'd1);
        a = 32'h0000_3004;
        check("pend_addr", im_addr, a);
        rst = 1'b0;
        #1;
        check("async_req_drop", {31'd0, im_req}, 32'd0);
        im_ack   = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_ack_instr", instr, 32'd0);
        im_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_addr_q.push_back(32'h0000_3000);
        fetch(32'h2442_0001, 1, 1'b0);
        check("sb_empty", exp_addr_q.size(), 32'd0);

        // Wrap-around instance: 0xFFFF_FFFC + 4 -> 0
        check("wrap_req", {31'd0, im_req2}, 32'd1);
        check("wrap_addr", im_addr2, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4_2, 32'h0000_0000);
        im_ack2   = 1'b1;
        im_rdata2 = 32'h0000_0000;
        @(negedge clk);
        im_ack2 = 1'b0;
        check("wrap_valid", {31'd0, instr_valid2}, 32'd1);
        PCWr2  = 1'b1;
        NPCOp2 = 2'b00;
        @(negedge clk);
        PCWr2 = 1'b0;
        check("wrap_next_addr", im_addr2, 32'h0000_0000);
        check("wrap_next_req", {31'd0, im_req2}, 32'd1);
        check("wrap_no_err", {31'd0, misalign_err2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
